uart_tx_axis: RTL and testbench

UART transmitter with an AXI-Stream byte input. It is the transmit end of the team's UART link and serialises frames the receive side decodes: start bit, DATA_BITS LSB-first, optional even/odd parity, stop bit(s). A one-entry holding register lets the upstream push the next word while the current frame shifts out, so back-to-back frames have no idle gap.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx_axis.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_axis.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive ends of the link.
//   uart_state_e : frame state encoding (common to tx and rx)
//   Parity*      : parity-mode strings accepted by the PARITY parameter
//   baud_div()   : clocks per bit for a given clock frequency and line rate
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam string ParityNone = "none";
  localparam string ParityEven = "even";
  localparam string ParityOdd  = "odd";

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses bit_end in the last clock of each bit.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   restart : synchronous restart, counter is 0 in the clock after it is seen
//   bit_end : high while the counter sits at BAUD_DIV-1
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(BAUD_DIV) + 1;

  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;

  assign bit_end = (baud_cnt_q == CntW'(BAUD_DIV - 1));

  always_comb begin
    baud_cnt_d = baud_cnt_q + 1'b1;
    if (restart || bit_end) begin
      baud_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_axis.sv
// UART transmitter fed by an AXI-Stream byte interface, with a one-word holding register so
// the next word can be queued while the current frame shifts out (no idle gap between frames).
//   clk, rst      : system clock, asynchronous active-high reset
//   s_axis_tdata  : word to transmit (DATA_BITS wide)
//   s_axis_tvalid : upstream word valid
//   s_axis_tready : holding register empty
//   tx            : registered serial line, idle high
//   busy          : a frame is on the line
//   tx_done       : one-clock pulse in the last clock of the final stop bit
module uart_tx_axis
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter string       PARITY    = "even",
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned BaudDiv   = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned BitCntW   = $clog2(DATA_BITS) + 1;
  localparam bit          HasParity = (PARITY != ParityNone);
  localparam bit          OddParity = (PARITY == ParityOdd);

  uart_state_e          state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_valid_q, hold_valid_d;

  logic bit_end, load, frame_end, last_data, last_stop, accept;

  uart_baud_gen #(
    .BAUD_DIV (BaudDiv)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (load),
    .bit_end (bit_end)
  );

  assign accept    = s_axis_tvalid && !hold_valid_q;
  assign last_data = (bit_cnt_q == BitCntW'(DATA_BITS - 1));
  assign last_stop = (stop_cnt_q == 2'(STOP_BITS - 1));
  assign frame_end = (state_q == StStop) && bit_end && last_stop;
  // A queued word starts either from idle or straight out of the final stop clock.
  assign load      = hold_valid_q && ((state_q == StIdle) || frame_end);

  assign s_axis_tready = !hold_valid_q;
  assign tx            = tx_q;
  assign busy          = (state_q != StIdle);
  assign tx_done       = frame_end;

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;

    if (accept) begin
      hold_data_d  = s_axis_tdata;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (last_data) begin
            if (HasParity) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_cnt_d = '0;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_cnt_d = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Load overrides the stop-to-idle transition so back-to-back frames have no gap.
    if (load) begin
      state_d      = StStart;
      tx_d         = 1'b0;
      shift_d      = hold_data_q;
      par_d        = OddParity ? ~^hold_data_q : ^hold_data_q;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      tx_q         <= 1'b1;
      shift_q      <= '0;
      par_q        <= 1'b0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_axis.sv
module tb_uart_tx_axis;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tvalid_e, tvalid_o, tvalid_n;
  logic       tready_e, tready_o, tready_n;
  logic       tx_e, tx_o, tx_n;
  logic       busy_e, busy_o, busy_n;
  logic       done_e, done_o, done_n;

  int checks = 0;
  int errors = 0;

  logic tx_log   [0:599];
  logic busy_log [0:599];
  logic done_log [0:599];
  logic rdy_log  [0:599];

  always #5 clk = ~clk;

  uart_tx_axis #(
    .CLK_FREQ (1_000_000), .BAUD (100_000), .DATA_BITS (8), .PARITY ("even"), .STOP_BITS (1)
  ) dut_e (
    .clk (clk), .rst (rst), .s_axis_tdata (tdata), .s_axis_tvalid (tvalid_e),
    .s_axis_tready (tready_e), .tx (tx_e), .busy (busy_e), .tx_done (done_e)
  );

  uart_tx_axis #(
    .CLK_FREQ (1_000_000), .BAUD (100_000), .DATA_BITS (8), .PARITY ("odd"), .STOP_BITS (1)
  ) dut_o (
    .clk (clk), .rst (rst), .s_axis_tdata (tdata), .s_axis_tvalid (tvalid_o),
    .s_axis_tready (tready_o), .tx (tx_o), .busy (busy_o), .tx_done (done_o)
  );

  uart_tx_axis #(
    .CLK_FREQ (1_000_000), .BAUD (100_000), .DATA_BITS (8), .PARITY ("none"), .STOP_BITS (2)
  ) dut_n (
    .clk (clk), .rst (rst), .s_axis_tdata (tdata), .s_axis_tvalid (tvalid_n),
    .s_axis_tready (tready_n), .tx (tx_n), .busy (busy_n), .tx_done (done_n)
  );

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0:       tvalid_e = v;
      1:       tvalid_o = v;
      default: tvalid_n = v;
    endcase
  endtask

  // Log index i holds the outputs seen in the clock after the (i+1)-th edge from the call.
  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (sel)
        0: begin
          tx_log[i] = tx_e; busy_log[i] = busy_e; done_log[i] = done_e; rdy_log[i] = tready_e;
        end
        1: begin
          tx_log[i] = tx_o; busy_log[i] = busy_o; done_log[i] = done_o; rdy_log[i] = tready_o;
        end
        default: begin
          tx_log[i] = tx_n; busy_log[i] = busy_n; done_log[i] = done_n; rdy_log[i] = tready_n;
        end
      endcase
    end
  endtask

  // Handshake on the next edge; returns at the negedge after it. The frame loads one edge later.
  task automatic start_word(input int sel, input logic [7:0] d);
    tdata = d;
    set_valid(sel, 1'b1);
    @(negedge clk);
    set_valid(sel, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; tdata = '0; tvalid_e = 0; tvalid_o = 0; tvalid_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_e, tx_o, tx_n} !== 3'b111) begin
      errors++; $display("FAIL reset_tx: got %b want 111", {tx_e, tx_o, tx_n});
    end
    checks++;
    if ({busy_e, busy_o, busy_n} !== 3'b000) begin
      errors++; $display("FAIL reset_busy: got %b want 000", {busy_e, busy_o, busy_n});
    end
    checks++;
    if ({done_e, done_o, done_n} !== 3'b000) begin
      errors++; $display("FAIL reset_done: got %b want 000", {done_e, done_o, done_n});
    end
    checks++;
    if ({tready_e, tready_o, tready_n} !== 3'b111) begin
      errors++; $display("FAIL reset_tready: got %b want 111", {tready_e, tready_o, tready_n});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_even_a5;
    logic [0:10] seq;
    int          ndone;
    seq = 11'b0_1010_0101_0_1;
    start_word(0, 8'hA5);
    checks++;
    if (tready_e !== 1'b0) begin
      errors++; $display("FAIL a5_tready_held: got %b want 0", tready_e);
    end
    capture(0, 120);
    ndone = 0;
    for (int i = 0; i < 120; i++) begin
      checks++;
      if (tx_log[i] !== ((i < 110) ? seq[i / 10] : 1'b1)) begin
        errors++; $display("FAIL a5_tx clk %0d: got %b want %b", i + 1, tx_log[i],
                           (i < 110) ? seq[i / 10] : 1'b1);
      end
      checks++;
      if (busy_log[i] !== (i < 110)) begin
        errors++; $display("FAIL a5_busy clk %0d: got %b want %b", i + 1, busy_log[i], i < 110);
      end
      checks++;
      if (done_log[i] !== (i == 109)) begin
        errors++; $display("FAIL a5_done clk %0d: got %b want %b", i + 1, done_log[i], i == 109);
      end
      checks++;
      if (rdy_log[i] !== 1'b1) begin
        errors++; $display("FAIL a5_tready clk %0d: got %b want 1", i + 1, rdy_log[i]);
      end
      if (done_log[i] === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL a5_done_count: got %0d want 1", ndone);
    end
  endtask

  task automatic test_odd;
    logic [7:0] words [0:1];
    logic       pars  [0:1];
    logic [7:0] data;
    words = '{8'h00, 8'h07};
    pars  = '{1'b1, 1'b0};
    for (int w = 0; w < 2; w++) begin
      start_word(1, words[w]);
      capture(1, 115);
      // Reference receiver: sample each bit in its middle clock.
      for (int k = 0; k < 8; k++) data[k] = tx_log[10 * (k + 1) + 5];
      checks++;
      if (tx_log[5] !== 1'b0) begin
        errors++; $display("FAIL odd_start w%0d: got %b want 0", w, tx_log[5]);
      end
      checks++;
      if (data !== words[w]) begin
        errors++; $display("FAIL odd_data w%0d: got %h want %h", w, data, words[w]);
      end
      checks++;
      if (tx_log[95] !== pars[w]) begin
        errors++; $display("FAIL odd_parity w%0d: got %b want %b", w, tx_log[95], pars[w]);
      end
      checks++;
      if (tx_log[105] !== 1'b1) begin
        errors++; $display("FAIL odd_stop w%0d: got %b want 1", w, tx_log[105]);
      end
      checks++;
      if (done_log[109] !== 1'b1 || busy_log[110] !== 1'b0) begin
        errors++; $display("FAIL odd_end w%0d: got done=%b busy=%b want done=1 busy=0", w,
                           done_log[109], busy_log[110]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  words [0:2];
    logic [0:32] seq;
    logic        pend;
    logic        exp_tx, exp_busy, exp_done, exp_rdy;
    int          k;
    words = '{8'h01, 8'hFF, 8'h3C};
    seq   = {11'b0_1000_0000_1_1, 11'b0_1111_1111_0_1, 11'b0_0011_1100_0_1};
    checks++;
    if (tready_e !== 1'b1) begin
      errors++; $display("FAIL b2b_initial_tready: got %b want 1", tready_e);
    end
    k = 0; tdata = words[0]; tvalid_e = 1'b1; pend = 1'b1;
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      if (pend) begin
        k++;
        if (k < 3) tdata = words[k];
        else tvalid_e = 1'b0;
        pend = 1'b0;
      end
      tx_log[c] = tx_e; busy_log[c] = busy_e; done_log[c] = done_e; rdy_log[c] = tready_e;
      if (tvalid_e && tready_e) pend = 1'b1;
    end
    for (int c = 0; c < 340; c++) begin
      exp_tx   = (c >= 1 && c <= 330) ? seq[(c - 1) / 10] : 1'b1;
      exp_busy = (c >= 1 && c <= 330);
      exp_done = (c == 110 || c == 220 || c == 330);
      exp_rdy  = (c == 1 || c == 111 || c >= 221);
      checks++;
      if (tx_log[c] !== exp_tx) begin
        errors++; $display("FAIL b2b_tx c%0d: got %b want %b", c, tx_log[c], exp_tx);
      end
      checks++;
      if (busy_log[c] !== exp_busy) begin
        errors++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy_log[c], exp_busy);
      end
      checks++;
      if (done_log[c] !== exp_done) begin
        errors++; $display("FAIL b2b_done c%0d: got %b want %b", c, done_log[c], exp_done);
      end
      checks++;
      if (rdy_log[c] !== exp_rdy) begin
        errors++; $display("FAIL b2b_tready c%0d: got %b want %b", c, rdy_log[c], exp_rdy);
      end
    end
    checks++;
    if (k !== 3) begin
      errors++; $display("FAIL b2b_accepts: got %0d want 3", k);
    end
  endtask

  task automatic test_none_2stop;
    logic [0:10] seq;
    seq = 11'b0_0011_1100_1_1;
    start_word(2, 8'h3C);
    capture(2, 115);
    for (int i = 0; i < 115; i++) begin
      checks++;
      if (tx_log[i] !== ((i < 110) ? seq[i / 10] : 1'b1)) begin
        errors++; $display("FAIL none_tx clk %0d: got %b want %b", i + 1, tx_log[i],
                           (i < 110) ? seq[i / 10] : 1'b1);
      end
      checks++;
      if (busy_log[i] !== (i < 110)) begin
        errors++; $display("FAIL none_busy clk %0d: got %b want %b", i + 1, busy_log[i], i < 110);
      end
      checks++;
      if (done_log[i] !== (i == 109)) begin
        errors++; $display("FAIL none_done clk %0d: got %b want %b", i + 1, done_log[i], i == 109);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [0:10] seq;
    seq = 11'b0_1111_0000_0_1;
    start_word(0, 8'hA5);
    @(negedge clk);                     // clk 1 of the frame, holding register empty again
    tdata = 8'h55; tvalid_e = 1'b1;
    @(negedge clk);                     // clk 2, 0x55 now held
    tvalid_e = 1'b0;
    checks++;
    if (tready_e !== 1'b0) begin
      errors++; $display("FAIL rst_mid_held: got tready=%b want 0", tready_e);
    end
    repeat (38) @(negedge clk);         // clk 40
    checks++;
    if (busy_e !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy_e);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_e, busy_e, tready_e, done_e} !== 4'b1010) begin
      errors++; $display("FAIL rst_mid_immediate: got tx,busy,rdy,done=%b want 1010",
                         {tx_e, busy_e, tready_e, done_e});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture(0, 30);
    for (int i = 0; i < 30; i++) begin
      checks++;
      if ({tx_log[i], busy_log[i], rdy_log[i]} !== 3'b101) begin
        errors++; $display("FAIL rst_mid_discard clk %0d: got tx,busy,rdy=%b want 101", i,
                           {tx_log[i], busy_log[i], rdy_log[i]});
      end
    end
    start_word(0, 8'h0F);
    capture(0, 115);
    for (int i = 0; i < 115; i++) begin
      checks++;
      if (tx_log[i] !== ((i < 110) ? seq[i / 10] : 1'b1)) begin
        errors++; $display("FAIL rst_0f_tx clk %0d: got %b want %b", i + 1, tx_log[i],
                           (i < 110) ? seq[i / 10] : 1'b1);
      end
    end
    checks++;
    if (done_log[109] !== 1'b1) begin
      errors++; $display("FAIL rst_0f_done: got %b want 1", done_log[109]);
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_e, tx_o, tx_n, busy_e, busy_o, busy_n, done_e, done_o, done_n,
           tready_e, tready_o, tready_n} !== 12'b111_000_000_111) begin
        errors++; $display("FAIL idle clk %0d: got %b want 111000000111", i,
                           {tx_e, tx_o, tx_n, busy_e, busy_o, busy_n, done_e, done_o, done_n,
                            tready_e, tready_o, tready_n});
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_a5();
    test_odd();
    test_back_to_back();
    test_none_2stop();
    test_reset_mid_frame();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
